stw_bist_sequencer: RTL and testbench

// Multi-pattern stop-the-world (STW) diagnosis sequencer for the BISR systolic array.

---
 rtl/stw_bist_sequencer_if.sv | 25 ++
 rtl/stw_bist_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_stw_bist_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stw_bist_sequencer_if.sv
// rtl/stw_bist_sequencer_if.sv - STW test handshake between the BIST sequencer and the systolic array
interface stw_bist_sequencer_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16
);
  logic                   STW_test_load_en;
  logic [WORD_SIZE-1:0]   STW_mult_op1;
  logic [WORD_SIZE-1:0]   STW_mult_op2;
  logic [WORD_SIZE-1:0]   STW_add_op;
  logic [WORD_SIZE-1:0]   STW_expected;
  logic                   STW_start;
  logic                   STW_complete;
  logic [ROWS*COLS-1:0]   STW_result_mat;

  modport master (
    output STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, STW_start,
    input  STW_complete, STW_result_mat
  );

  modport slave (
    input  STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, STW_start,
    output STW_complete, STW_result_mat
  );
endinterface

// File: rtl/stw_bist_sequencer.sv
// rtl/stw_bist_sequencer.sv - multi-pattern stop-the-world diagnosis sequencer building a PE fault map
module stw_bist_sequencer #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int WORD_SIZE    = 16,
  parameter int NUM_PATTERNS = 4,
  parameter int TIMEOUT      = 64,
  localparam int NPE = ROWS * COLS,
  localparam int NW  = $clog2(NUM_PATTERNS + 1),
  localparam int AW  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int CW  = $clog2(NPE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NW-1:0]        cfg_num_pat,
  input  logic                 pat_wr_en,
  input  logic [AW-1:0]        pat_wr_addr,
  input  logic [WORD_SIZE-1:0] pat_wr_op1,
  input  logic [WORD_SIZE-1:0] pat_wr_op2,
  input  logic [WORD_SIZE-1:0] pat_wr_add,
  stw_bist_sequencer_if.master stw,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [NPE-1:0]       fault_map,
  output logic [CW-1:0]        fault_count
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ACCUM = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [NW-1:0]        num_q, num_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NPE-1:0]       result_q, result_d;
  logic [NPE-1:0]       fault_map_q, fault_map_d;
  logic [CW-1:0]        fault_count_q, fault_count_d;
  logic                 timeout_q, timeout_d;

  logic [WORD_SIZE-1:0] mem_op1_q [NUM_PATTERNS];
  logic [WORD_SIZE-1:0] mem_op2_q [NUM_PATTERNS];
  logic [WORD_SIZE-1:0] mem_add_q [NUM_PATTERNS];

  logic                 mem_we;
  logic                 stw_active;
  logic [WORD_SIZE-1:0] rd_op1, rd_op2, rd_add, golden;
  logic [CW-1:0]        popcnt;

  // Memory is frozen while busy, so reading it live keeps the operands stable across START/WAIT.
  always_comb begin
    mem_we     = (state_q == S_IDLE) && pat_wr_en && (32'(pat_wr_addr) < 32'(NUM_PATTERNS));
    stw_active = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT);
    rd_op1     = mem_op1_q[idx_q];
    rd_op2     = mem_op2_q[idx_q];
    rd_add     = mem_add_q[idx_q];
    golden     = rd_op1 * rd_op2 + rd_add;
  end

  always_comb begin
    stw.STW_test_load_en = (state_q == S_LOAD);
    stw.STW_start        = (state_q == S_START);
    stw.STW_mult_op1     = stw_active ? rd_op1 : '0;
    stw.STW_mult_op2     = stw_active ? rd_op2 : '0;
    stw.STW_add_op       = stw_active ? rd_add : '0;
    stw.STW_expected     = stw_active ? golden : '0;
    busy                 = (state_q != S_IDLE);
    done                 = (state_q == S_DONE);
    timeout              = timeout_q;
    fault_map            = fault_map_q;
    fault_count          = fault_count_q;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    num_d         = num_q;
    timer_d       = timer_q;
    result_d      = result_q;
    fault_map_d   = fault_map_q;
    fault_count_d = fault_count_q;
    timeout_d     = timeout_q;
    popcnt        = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          num_d         = (cfg_num_pat > NW'(NUM_PATTERNS)) ? NW'(NUM_PATTERNS) : cfg_num_pat;
          idx_d         = '0;
          fault_map_d   = '0;
          fault_count_d = '0;
          timeout_d     = 1'b0;
          state_d       = (num_d == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stw.STW_complete) begin
          result_d = stw.STW_result_mat;
          state_d  = S_ACCUM;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d   = 1'b1;
          fault_map_d = '1;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACCUM: begin
        fault_map_d = fault_map_q | ~result_q;
        if ((NW'(idx_q) + NW'(1)) == num_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort freezes the results exactly as they stood; the count is never refreshed.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      fault_map_d   = fault_map_q;
      fault_count_d = fault_count_q;
      timeout_d     = timeout_q;
    end

    // The count is registered on entry to DONE so it is already valid during the done pulse.
    for (int i = 0; i < NPE; i++) begin
      popcnt = popcnt + CW'(fault_map_d[i]);
    end
    if (state_d == S_DONE) begin
      fault_count_d = popcnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      num_q         <= '0;
      timer_q       <= '0;
      result_q      <= '0;
      fault_map_q   <= '0;
      fault_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      timer_q       <= timer_d;
      result_q      <= result_d;
      fault_map_q   <= fault_map_d;
      fault_count_q <= fault_count_d;
      timeout_q     <= timeout_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PATTERNS; i++) begin
        mem_op1_q[i] <= '0;
        mem_op2_q[i] <= '0;
        mem_add_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_op1_q[pat_wr_addr] <= pat_wr_op1;
      mem_op2_q[pat_wr_addr] <= pat_wr_op2;
      mem_add_q[pat_wr_addr] <= pat_wr_add;
    end
  end
endmodule

// File: tb/tb_stw_bist_sequencer.sv
// tb/tb_stw_bist_sequencer.sv - scoreboard bench for the STW BIST sequencer with a stub array
`timescale 1ns/1ps
module tb_stw_bist_sequencer;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;
  localparam int NP   = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  cfg_num_pat = '0;
  logic        pat_wr_en = 1'b0;
  logic [1:0]  pat_wr_addr = '0;
  logic [15:0] pat_wr_op1 = '0;
  logic [15:0] pat_wr_op2 = '0;
  logic [15:0] pat_wr_add = '0;
  logic        busy, done, timeout;
  logic [15:0] fault_map;
  logic [4:0]  fault_count;

  stw_bist_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) stw ();

  stw_bist_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .NUM_PATTERNS(NP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_num_pat(cfg_num_pat),
    .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_op1(pat_wr_op1),
    .pat_wr_op2(pat_wr_op2), .pat_wr_add(pat_wr_add), .stw(stw), .busy(busy),
    .done(done), .timeout(timeout), .fault_map(fault_map), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] map;
    logic [4:0]  cnt;
    logic        to;
    int          lat;
  } res_t;

  res_t        res_q[$];
  logic [15:0] gold_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  logic [15:0] m_op1[NP], m_op2[NP], m_add[NP];
  int          stub_lat = 2;
  bit          stub_hang = 1'b0;
  logic [15:0] stub_fail[NP];
  int          stub_pat = 0;
  int          stub_cnt = 0;
  bit          stub_act = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stub array plus output monitor, both acting on the falling edge.
  always @(negedge clk) begin
    res_t r;
    stw.STW_complete = 1'b0;
    if (!busy) begin
      stub_act = 1'b0;
      stub_pat = 0;
    end else if (stw.STW_start) begin
      stub_act = 1'b1;
      stub_cnt = 0;
    end else if (stub_act && !stub_hang) begin
      stub_cnt++;
      if (stub_cnt == stub_lat) begin
        stw.STW_complete   = 1'b1;
        stw.STW_result_mat = ~stub_fail[stub_pat % NP];
        stub_pat++;
        stub_act = 1'b0;
      end
    end
    if (stw.STW_test_load_en) begin
      if (gold_q.size() == 0) check("load_unexpected", 1, 0);
      else check("stw_expected", 32'(stw.STW_expected), 32'(gold_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      if (res_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        r = res_q.pop_front();
        check("fault_map", 32'(fault_map), 32'(r.map));
        check("fault_count", 32'(fault_count), 32'(r.cnt));
        check("timeout", 32'(timeout), 32'(r.to));
        check("done_latency", 32'(cyc - start_cyc), 32'(r.lat));
      end
    end
  end

  task automatic write_pat(input int a, input logic [15:0] o1, input logic [15:0] o2,
                           input logic [15:0] ad);
    @(negedge clk);
    pat_wr_en = 1'b1; pat_wr_addr = 2'(a);
    pat_wr_op1 = o1; pat_wr_op2 = o2; pat_wr_add = ad;
    m_op1[a] = o1; m_op2[a] = o2; m_add[a] = ad;
    @(negedge clk);
    pat_wr_en = 1'b0;
  endtask

  task automatic push_gold(input int nloads);
    logic [31:0] full;
    for (int i = 0; i < nloads; i++) begin
      full = 32'(m_op1[i]) * 32'(m_op2[i]) + 32'(m_add[i]);
      gold_q.push_back(full[15:0]);
    end
  endtask

  task automatic run(input int cfg, input int nloads, input logic [15:0] map,
                     input logic [4:0] cnt, input bit to, input int lat);
    res_t r;
    int   d0;
    push_gold(nloads);
    r.map = map; r.cnt = cnt; r.to = to; r.lat = lat;
    res_q.push_back(r);
    @(negedge clk);
    cfg_num_pat = 3'(cfg); start = 1'b1; start_cyc = cyc; d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
    if (done_cnt == d0) begin
      check("done_wait", 0, 1);
      res_q.delete();
      gold_q.delete();
    end
    repeat (2) @(negedge clk);
    check("done_once", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < NP; i++) begin
      stub_fail[i] = '0; m_op1[i] = '0; m_op2[i] = '0; m_add[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_map", 32'(fault_map), 0);
    check("rst_count", 32'(fault_count), 0);
    check("rst_load_en", 32'(stw.STW_test_load_en), 0);
    check("rst_expected", 32'(stw.STW_expected), 0);
    rst = 1'b1;

    // single all-pass pattern
    write_pat(0, 16'd4, 16'd3, 16'd0);
    stub_lat = 5;
    run(1, 1, 16'h0000, 5'd0, 1'b0, 9);

    // three patterns, PE(0,1) fails on pattern 0 and PE(2,2) on pattern 2
    write_pat(1, 16'd100, 16'd7, 16'd9);
    write_pat(2, 16'h1234, 16'h0010, 16'h0001);
    stub_fail[0] = 16'h0002; stub_fail[2] = 16'h0400; stub_lat = 2;
    run(3, 3, 16'h0402, 5'd2, 1'b0, 16);

    // array never completes
    for (int i = 0; i < NP; i++) stub_fail[i] = '0;
    stub_hang = 1'b1;
    run(1, 1, 16'hFFFF, 5'd16, 1'b1, TMO + 3);
    stub_hang = 1'b0;

    // truncating golden, cfg above depth clamps to 4, then an empty run
    write_pat(3, 16'hFFFF, 16'd2, 16'd5);
    stub_lat = 1;
    run(7, 4, 16'h0000, 5'd0, 1'b0, 17);
    run(0, 0, 16'h0000, 5'd0, 1'b0, 1);

    // abort in WAIT of pattern 1, with start and a write attempted while busy
    stub_fail[0] = 16'h0020; stub_lat = 4;
    push_gold(2);
    @(negedge clk);
    cfg_num_pat = 3'd3; start = 1'b1; d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; pat_wr_en = 1'b1; pat_wr_addr = 2'd0;
    pat_wr_op1 = 16'hDEAD; pat_wr_op2 = 16'hBEEF; pat_wr_add = 16'h1111;
    @(negedge clk);
    start = 1'b0; pat_wr_en = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_partial_map", 32'(fault_map), 32'h0020);
    check("abort_count", 32'(fault_count), 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_loads", 32'(gold_q.size()), 0);
    gold_q.delete();
    stub_fail[0] = '0; stub_lat = 5;
    run(1, 1, 16'h0000, 5'd0, 1'b0, 9);

    // reset in the middle of WAIT
    write_pat(1, 16'd5, 16'd6, 16'd7);
    stub_lat = 10;
    push_gold(1);
    @(negedge clk);
    cfg_num_pat = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_start", 32'(stw.STW_start), 0);
    check("midrst_op1", 32'(stw.STW_mult_op1), 0);
    check("midrst_map", 32'(fault_map), 0);
    gold_q.delete();
    res_q.delete();
    for (int i = 0; i < NP; i++) begin
      m_op1[i] = '0; m_op2[i] = '0; m_add[i] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    write_pat(1, 16'd5, 16'd6, 16'd7);
    stub_fail[1] = 16'h8000; stub_lat = 3;
    run(2, 2, 16'h8000, 5'd1, 1'b0, 13);

    check("gold_q_empty", 32'(gold_q.size()), 0);
    check("res_q_empty", 32'(res_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
